// File: rtl/ceespu_pkg.sv
// Shared encodings for the ceespu memory stage: access sizes, writeback sources,
// FSM states and the writeback source mux.
package ceespu_pkg;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;
  localparam int         SEL_ZEXT_BIT = 2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;

  typedef enum logic {IDLE, REQ} mem_state_e;

  // Code 3 falls back to the ALU result; the link value wraps within 14 bits.
  function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                            input logic [31:0] alu,
                                            input logic [31:0] load,
                                            input logic [13:0] pc);
    logic [13:0] pc_next;
    logic [31:0] result;
    pc_next = pc + 14'd1;
    case (sel)
      WB_LOAD: result = load;
      WB_PC:   result = {18'b0, pc_next};
      default: result = alu;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ceespu_load_align.sv
// Extracts the addressed byte/half from a bus read word and sign- or zero-extends it.
module ceespu_load_align
  import ceespu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (addr_lo)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    // Half lane follows addr[0] to line up with execute's 4'b1100/4'b0011 enables.
    half_v = addr_lo[0] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_HALF: data = {{16{~zext & half_v[15]}}, half_v};
      SIZE_BYTE: data = {{24{~zext & byte_v[7]}}, byte_v};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/ceespu_memory_stage.sv
// ceespu memory stage: runs one req/ack data-bus transaction per memory op and
// forms the registered writeback value; stalls upstream while the bus is busy.
module ceespu_memory_stage
  import ceespu_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_memE,
  input  logic        I_memWrite,
  input  logic [3:0]  I_memWe,
  input  logic [31:0] I_memAddress,
  input  logic [31:0] I_storeData,
  input  logic [2:0]  I_selMem,
  input  logic [31:0] I_aluResult,
  input  logic [1:0]  I_selWb,
  input  logic        I_we,
  input  logic [4:0]  I_regD,
  input  logic [13:0] I_PC,
  output logic        O_busReq,
  output logic [31:0] O_busAddr,
  output logic [31:0] O_busWdata,
  output logic [3:0]  O_busWe,
  input  logic        I_busAck,
  input  logic [31:0] I_busRdata,
  output logic        O_we,
  output logic [4:0]  O_regD,
  output logic [31:0] O_wbData,
  output logic        O_busy
);

  mem_state_e  state, state_next;
  logic [1:0]  size_q;
  logic        zext_q;
  logic [1:0]  selwb_q;
  logic        rf_we_q;
  logic [4:0]  regd_q;
  logic [13:0] pc_q;
  logic [31:0] alu_q;
  logic [31:0] load_data;

  ceespu_load_align u_align (
    .rdata   (I_busRdata),
    .addr_lo (O_busAddr[1:0]),
    .size    (size_q),
    .zext    (zext_q),
    .data    (load_data)
  );

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    O_busy     = 1'b0;
    case (state)
      IDLE: if (I_memE) begin
        O_busy     = 1'b1;
        state_next = REQ;
      end
      REQ: if (I_busAck) state_next = IDLE;
           else          O_busy     = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  assign O_busReq = (state == REQ);

  // The whole request is captured on accept so upstream may move on after the ack.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      O_busAddr  <= '0;
      O_busWdata <= '0;
      O_busWe    <= '0;
      O_we       <= 1'b0;
      O_regD     <= '0;
      O_wbData   <= '0;
      size_q     <= '0;
      zext_q     <= 1'b0;
      selwb_q    <= '0;
      rf_we_q    <= 1'b0;
      regd_q     <= '0;
      pc_q       <= '0;
      alu_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_memE) begin
            O_busAddr  <= I_memAddress;
            O_busWdata <= I_storeData;
            O_busWe    <= I_memWrite ? I_memWe : 4'b0000;
            size_q     <= I_selMem[1:0];
            zext_q     <= I_selMem[SEL_ZEXT_BIT];
            selwb_q    <= I_selWb;
            rf_we_q    <= I_we;
            regd_q     <= I_regD;
            pc_q       <= I_PC;
            alu_q      <= I_aluResult;
            O_we       <= 1'b0;
          end else begin
            O_we     <= I_we;
            O_regD   <= I_regD;
            O_wbData <= wb_select(I_selWb, I_aluResult, 32'h0, I_PC);
          end
        end
        REQ: begin
          if (I_busAck) begin
            O_we     <= rf_we_q;
            O_regD   <= regd_q;
            O_wbData <= wb_select(selwb_q, alu_q, load_data, pc_q);
          end else begin
            O_we <= 1'b0;
          end
        end
        default: O_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ceespu_memory_stage.sv
// Scoreboard bench for ceespu_memory_stage: expected writebacks are queued when an
// op is driven and compared when the stage retires it.
module tb_ceespu_memory_stage;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_memE = 1'b0;
  logic        I_memWrite = 1'b0;
  logic [3:0]  I_memWe = '0;
  logic [31:0] I_memAddress = '0;
  logic [31:0] I_storeData = '0;
  logic [2:0]  I_selMem = '0;
  logic [31:0] I_aluResult = '0;
  logic [1:0]  I_selWb = '0;
  logic        I_we = 1'b0;
  logic [4:0]  I_regD = '0;
  logic [13:0] I_PC = '0;
  logic        I_busAck = 1'b0;
  logic [31:0] I_busRdata = '0;
  logic        O_busReq;
  logic [31:0] O_busAddr;
  logic [31:0] O_busWdata;
  logic [3:0]  O_busWe;
  logic        O_we;
  logic [4:0]  O_regD;
  logic [31:0] O_wbData;
  logic        O_busy;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t expQ[$];
  int  numChecks = 0;
  int  numFails  = 0;

  ceespu_memory_stage dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_memE(I_memE), .I_memWrite(I_memWrite),
    .I_memWe(I_memWe), .I_memAddress(I_memAddress), .I_storeData(I_storeData),
    .I_selMem(I_selMem), .I_aluResult(I_aluResult), .I_selWb(I_selWb),
    .I_we(I_we), .I_regD(I_regD), .I_PC(I_PC), .O_busReq(O_busReq),
    .O_busAddr(O_busAddr), .O_busWdata(O_busWdata), .O_busWe(O_busWe),
    .I_busAck(I_busAck), .I_busRdata(I_busRdata), .O_we(O_we),
    .O_regD(O_regD), .O_wbData(O_wbData), .O_busy(O_busy)
  );

  always #5 I_clk = ~I_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference load extraction built from shifts rather than lane muxes.
  function automatic logic [31:0] refLoad(input logic [31:0] rdata, input logic [31:0] addr, input logic [2:0] selMem);
    logic [31:0] sh;
    logic [31:0] res;
    res = rdata;
    if (selMem[1:0] == 2'd2) begin
      sh  = rdata >> (addr[1:0] * 8);
      res = selMem[2] ? (sh & 32'hFF) : 32'(signed'(sh[7:0]));
    end else if (selMem[1:0] == 2'd1) begin
      sh  = addr[0] ? (rdata >> 16) : rdata;
      res = selMem[2] ? (sh & 32'hFFFF) : 32'(signed'(sh[15:0]));
    end
    return res;
  endfunction

  function automatic logic [31:0] refWb(input logic [1:0] sel, input logic [31:0] alu,
                                        input logic [31:0] load, input logic [13:0] pc);
    logic [13:0] link;
    link = pc + 14'd1;
    if (sel == 2'd1)      return load;
    else if (sel == 2'd2) return {18'b0, link};
    else                  return alu;
  endfunction

  task automatic popAndCheck(input string tag);
    wb_t e;
    numChecks++;
    if (expQ.size() == 0) begin
      numFails++;
      $display("[TB] FAIL %s_queue: got empty scoreboard, expected one entry", tag);
    end else begin
      numChecks--;
      e = expQ.pop_front();
      checkOutput({tag, "_we"}, 32'(O_we), 32'(e.we));
      checkOutput({tag, "_rd"}, 32'(O_regD), 32'(e.rd));
      checkOutput({tag, "_data"}, O_wbData, e.data);
    end
  endtask

  // Called at a negedge; returns at the negedge after the op has written back.
  task automatic applyStimulus(input string tag, input logic memE, input logic memWrite,
                               input logic [3:0] memWe, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [2:0] selMem,
                               input logic [31:0] alu, input logic [1:0] selWb,
                               input logic we, input logic [4:0] rd, input logic [13:0] pc,
                               input int waits, input logic [31:0] rdata, input logic idleAck);
    wb_t e;
    int  busyCycles;
    I_memE = memE; I_memWrite = memWrite; I_memWe = memWe; I_memAddress = addr;
    I_storeData = sdata; I_selMem = selMem; I_aluResult = alu; I_selWb = selWb;
    I_we = we; I_regD = rd; I_PC = pc;
    I_busAck = idleAck; I_busRdata = 32'hDEAD0BAD;
    e.we   = we;
    e.rd   = rd;
    e.data = refWb(selWb, alu, memE ? refLoad(rdata, addr, selMem) : 32'h0, pc);
    expQ.push_back(e);
    busyCycles = 0;
    #1;
    if (!memE) begin
      checkOutput({tag, "_busy"}, 32'(O_busy), 32'd0);
      @(posedge I_clk); @(negedge I_clk);
    end else begin
      if (O_busy) busyCycles++;
      @(posedge I_clk); @(negedge I_clk);
      checkOutput({tag, "_req"}, 32'(O_busReq), 32'd1);
      checkOutput({tag, "_addr"}, O_busAddr, addr);
      checkOutput({tag, "_busWe"}, 32'(O_busWe), memWrite ? 32'(memWe) : 32'd0);
      if (memWrite) checkOutput({tag, "_wdata"}, O_busWdata, sdata);
      checkOutput({tag, "_bubble"}, 32'(O_we), 32'd0);
      for (int i = 0; i < waits; i++) begin
        if (O_busy) busyCycles++;
        @(posedge I_clk); @(negedge I_clk);
      end
      I_busAck = 1'b1; I_busRdata = rdata;
      #1;
      if (O_busy) busyCycles++;
      checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'(1 + waits));
      @(posedge I_clk); @(negedge I_clk);
      checkOutput({tag, "_reqDrop"}, 32'(O_busReq), 32'd0);
    end
    popAndCheck(tag);
    I_memE = 1'b0; I_busAck = 1'b0; I_memWrite = 1'b0; I_we = 1'b0;
  endtask

  initial begin
    @(negedge I_clk); @(negedge I_clk);
    checkOutput("rst_busReq", 32'(O_busReq), 32'd0);
    checkOutput("rst_we", 32'(O_we), 32'd0);
    checkOutput("rst_busy", 32'(O_busy), 32'd0);
    checkOutput("rst_busWe", 32'(O_busWe), 32'd0);
    checkOutput("rst_wbData", O_wbData, 32'd0);
    checkOutput("rst_busAddr", O_busAddr, 32'd0);
    checkOutput("rst_wdata", O_busWdata, 32'd0);
    checkOutput("rst_regD", 32'(O_regD), 32'd0);
    I_rst = 1'b0;
    @(negedge I_clk);

    applyStimulus("alu", 0, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h12345678, 2'd0, 1, 5'd3, 14'h0, 0, 32'h0, 0);
    applyStimulus("ldb", 1, 0, 4'hF, 32'h103, 32'h0, 3'b010, 32'h0, 2'd1, 1, 5'd5, 14'h10, 2, 32'h80FF0000, 0);
    applyStimulus("ldhu", 1, 0, 4'h0, 32'h201, 32'h0, 3'b101, 32'h0, 2'd1, 1, 5'd6, 14'h11, 0, 32'hBEEF1234, 0);
    applyStimulus("stb", 1, 1, 4'b0100, 32'h402, 32'hABABABAB, 3'b010, 32'h104, 2'd0, 0, 5'd0, 14'h12, 0, 32'h0, 0);
    applyStimulus("link", 0, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h5555, 2'd2, 1, 5'd31, 14'h3FFF, 0, 32'h0, 0);
    applyStimulus("sel3", 0, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'hCAFEF00D, 2'd3, 1, 5'd7, 14'h20, 0, 32'h0, 0);
    applyStimulus("idleAck", 0, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h0BADBEEF, 2'd0, 1, 5'd8, 14'h21, 0, 32'h0, 1);
    applyStimulus("ldw", 1, 0, 4'h0, 32'h301, 32'h0, 3'b000, 32'h0, 2'd1, 1, 5'd9, 14'h22, 1, 32'hDEADBEEF, 0);
    applyStimulus("ldh", 1, 0, 4'h0, 32'h300, 32'h0, 3'b001, 32'h0, 2'd1, 1, 5'd10, 14'h23, 0, 32'h12348001, 0);
    applyStimulus("ldbu", 1, 0, 4'h0, 32'h501, 32'h0, 3'b110, 32'h0, 2'd1, 1, 5'd11, 14'h24, 3, 32'h0000AB00, 0);
    applyStimulus("ldLink", 1, 0, 4'h0, 32'h600, 32'h0, 3'b000, 32'h0, 2'd2, 1, 5'd12, 14'h0100, 0, 32'h77777777, 0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = $urandom;
      applyStimulus("rndLd", 1, 0, 4'h0, a, 32'h0, 3'($urandom_range(0, 6)), 32'h0, 2'd1, 1,
                    5'($urandom_range(1, 31)), 14'h30, $urandom_range(0, 3), $urandom, 0);
    end

    // Reset while a request is outstanding must withdraw it at once.
    I_memE = 1'b1; I_memAddress = 32'h700; I_selMem = 3'b000; I_we = 1'b1; I_regD = 5'd13;
    @(posedge I_clk); @(negedge I_clk);
    checkOutput("midReq_req", 32'(O_busReq), 32'd1);
    I_memE = 1'b0;
    I_rst  = 1'b1;
    #1;
    checkOutput("midReq_reqDrop", 32'(O_busReq), 32'd0);
    checkOutput("midReq_we", 32'(O_we), 32'd0);
    checkOutput("midReq_busy", 32'(O_busy), 32'd0);
    @(negedge I_clk);
    I_rst = 1'b0;
    applyStimulus("postRst", 0, 0, 4'h0, 32'h0, 32'h0, 3'b000, 32'h00C0FFEE, 2'd0, 1, 5'd14, 14'h0, 0, 32'h0, 0);

    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, expected finish before 200000");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule

// File: doc/ceespu_memory_stage.md
# ceespu_memory_stage

Memory-access stage of the ceespu pipeline, sitting between execute and writeback. It consumes the execute stage's memory request (address, replicated store data, byte enables, access size), runs a req/ack transaction on the data bus, and extracts, aligns and sign-/zero-extends load data. It also forms the writeback value and raises a stall while a bus transaction is outstanding.

## Interface
Parameters:
- none; all widths fixed: 32-bit data, 14-bit PC, 5-bit register index.

Ports:
- I_clk  in  1  single clock; all state on rising edge
- I_rst  in  1  reset, asynchronous, active-high
- I_memE  in  1  memory access this instruction
- I_memWrite  in  1  access is a store (I_memWe is don't-care when 0)
- I_memWe  in  4  byte enables from execute
- I_memAddress  in  32  byte address
- I_storeData  in  32  store data, already lane-replicated
- I_selMem  in  3  [1:0] size: 0 word, 1 half, 2 byte; [2] 1 = zero-extend, 0 = sign-extend
- I_aluResult  in  32  ALU result
- I_selWb  in  2  writeback source: 0 ALU, 1 load, 2 PC+1
- I_we, I_regD, I_PC  in  1/5/14  writeback enable, destination, PC
- O_busReq  out  1  bus request, held until ack
- O_busAddr  out  32  latched address
- O_busWdata  out  32  latched store data
- O_busWe  out  4  latched byte enables; 4'b0000 for loads
- I_busAck  in  1  bus completes transaction this cycle
- I_busRdata  in  32  read data, valid with I_busAck
- O_we  out  1  writeback enable
- O_regD  out  5  writeback destination
- O_wbData  out  32  writeback data
- O_busy  out  1  stall upstream; upstream holds its inputs while high

## Operation
- FSM states IDLE, REQ.
- IDLE, I_memE=0: pass-through. Next edge: O_we<=I_we, O_regD<=I_regD, O_wbData<=mux(I_selWb). O_busy=0.
- IDLE, I_memE=1: O_busy=1 combinationally. Next edge: latch address, store data, size, extend, write flag, selWb, we, regD, PC; O_we<=0 (bubble); go REQ.
- REQ: O_busReq=1, bus outputs from latched registers. Without I_busAck: O_busy=1, O_we<=0, stay. With I_busAck: O_busy=0 same cycle; next edge O_wbData<=mux(latched selWb, aligned load), O_we<=latched we, O_regD<=latched regD, go IDLE.
- O_busWe = latched I_memWe when write flag set, else 4'b0000; x inputs never reach the bus.
- Load alignment: byte lane = addr[1:0] (lane 0 = bits 7:0); half selects bits 31:16 when addr[0]=1, else 15:0 (matches execute's 4'b1100/4'b0011 enables); word unrotated. Extend per selMem[2].
- selWb=2: O_wbData = {18'b0, PC+1} (14-bit add, wraps).
- selWb=3: O_wbData = ALU result.
- Misaligned word access: no trap; address passed unchanged.
- I_busAck in IDLE is ignored.

## Timing
- Reset (async): state IDLE; O_busReq, O_we, O_busy, O_busWe, O_regD, O_wbData, O_busAddr, O_busWdata all 0. Reset mid-REQ abandons the transaction; bus must tolerate request withdrawal.
- Non-memory op: 1-cycle latency to writeback.
- Memory op: minimum 2 cycles (accept, ack in first REQ cycle); +1 per wait cycle.
- Back-to-back memory ops: the second op is accepted in the IDLE cycle following the ack edge; no overlap.
- O_busy is purely combinational from state, I_memE and I_busAck; no registered stall.

## Structure
- ceespu_pkg: selMem size codes, extend bit, selWb codes, FSM state enum.
- Sub-module ceespu_load_align: combinational (rdata, addr[1:0], size, zext) → 32-bit aligned value; unit-testable alone.
- Target 150–250 lines RTL.

## Test plan
- Reset mid-REQ: assert I_rst while O_busReq=1 → O_busReq, O_we, O_busy drop to 0 immediately; IDLE after release.
- ALU op, I_aluResult=0x12345678, I_we=1, regD=3 → next cycle O_we=1, O_regD=3, O_wbData=0x12345678, O_busy never high.
- Signed byte load, addr=0x103, selMem=3'b010, ack after 2 wait cycles with rdata=0x80FF0000 → O_busy high 3 cycles; O_wbData=0xFFFFFF80; O_busWe=0000.
- Zero-extend half load, addr=0x201, selMem=3'b101, rdata=0xBEEF1234 → O_wbData=0x0000BEEF.
- Store byte, I_memWe=0100, data=0xABABABAB, ack immediately → O_busWe=0100, O_busWdata=0xABABABAB, O_we=0, 2-cycle occupancy.
- selWb=2, PC=0x3FFF → O_wbData=0x00000000 (wrap).
